uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_receiver_if.sv | 10 +
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_receiver.sv | 124 ++++++++++++
 tb/tb_uart_receiver.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants and the baud divisor helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    localparam int OVERSAMPLE = 16;

    // Mid-bit sample points within a 16-tick bit; the bit is decided on the last one.
    localparam logic [3:0] SAMPLE_A = 4'd7;
    localparam logic [3:0] SAMPLE_B = 4'd8;
    localparam logic [3:0] SAMPLE_C = 4'd9;

    // Rounded clock divisor for 16x oversampling.
    function automatic int uart_div(input int clkHz, input int baud);
        return (clkHz + baud * 8) / (baud * 16);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver output bundle, matching the RX FIFO write side (data/strobe) plus status.
interface uart_receiver_if;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_frameErr;
    logic       o_busy;

    modport master (output o_valid, output o_data, output o_frameErr, output o_busy);
    modport slave  (input  o_valid, input  o_data, input  o_frameErr, input  o_busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: one-cycle tick every DIV cycles, phase reset by i_clr.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_clr,
    output logic o_tick
);
    localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            cnt <= '0;
        end else if (i_clr || o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign o_tick = !i_clr && (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// Emits one-cycle o_valid per good byte, or o_frameErr when the stop bit is low.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic            i_clk,
    input  logic            i_resetn,
    input  logic            i_serialIn,
    uart_receiver_if.master rx
);
    localparam int DIV = uart_div(CLK_FREQ, BAUD);

    logic        syncMeta;
    logic        rxs;
    logic [1:0]  syncFill;
    logic        armed;
    uart_state_e state;
    logic [3:0]  tcnt;
    logic [3:0]  bitIdx;
    logic [7:0]  shreg;
    logic        samp0;
    logic        samp1;
    logic        tick;
    logic        majority;
    logic        decide;

    // syncFill marks when rxs reflects a real pin sample rather than the reset value,
    // so a reset released on a low line cannot arm the receiver.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            syncMeta <= 1'b1;
            rxs      <= 1'b1;
            syncFill <= 2'b00;
        end else begin
            syncMeta <= i_serialIn;
            rxs      <= syncMeta;
            syncFill <= {syncFill[0], 1'b1};
        end
    end

    uart_baud_tick #(.DIV(DIV)) baudTick (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_clr    (state == IDLE),
        .o_tick   (tick)
    );

    assign majority = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
    assign decide   = tick && (tcnt == SAMPLE_C);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state         <= IDLE;
            armed         <= 1'b0;
            tcnt          <= '0;
            bitIdx        <= '0;
            shreg         <= '0;
            samp0         <= 1'b0;
            samp1         <= 1'b0;
            rx.o_valid    <= 1'b0;
            rx.o_frameErr <= 1'b0;
            rx.o_data     <= '0;
        end else begin
            rx.o_valid    <= 1'b0;
            rx.o_frameErr <= 1'b0;

            if (syncFill[1] && rxs) armed <= 1'b1;

            if (state != IDLE && tick) begin
                tcnt <= tcnt + 4'd1;
                if (tcnt == SAMPLE_A) samp0 <= rxs;
                if (tcnt == SAMPLE_B) samp1 <= rxs;
            end

            case (state)
                IDLE: begin
                    if (armed && !rxs) begin
                        state  <= START;
                        tcnt   <= '0;
                        bitIdx <= '0;
                    end
                end
                START: begin
                    if (decide && majority) begin
                        state <= IDLE;
                    end else if (tick && tcnt == 4'(OVERSAMPLE - 1)) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (decide) begin
                        shreg  <= {majority, shreg[7:1]};
                        bitIdx <= bitIdx + 4'd1;
                        if (bitIdx == 4'd7) state <= STOP;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit gives half a bit of resync margin.
                    if (decide) begin
                        if (majority) begin
                            rx.o_data  <= shreg;
                            rx.o_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            rx.o_frameErr <= 1'b1;
                            state         <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx.o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at DIV=10 (160 clocks per bit).
module tb_uart_receiver;

    localparam int BIT = 160;

    typedef struct {
        logic        isErr;
        logic [7:0]  data;
        bit          chkLat;
        int          startCyc;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_resetn = 1'b0;
    logic i_serialIn = 1'b1;
    int   cycleCnt = 0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] lastGood = 8'h00;
    exp_t expQ[$];

    uart_receiver_if rxIf();

    uart_receiver #(.CLK_FREQ(1_600_000), .BAUD(10_000)) dut (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_serialIn (i_serialIn),
        .rx         (rxIf)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cycleCnt <= cycleCnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at cycle %0d", tag, got, exp, cycleCnt);
        end else begin
            $display("ok   %s: %0h at cycle %0d", tag, got, cycleCnt);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (rxIf.o_valid || rxIf.o_frameErr) begin
            exp_t e;
            check("strobeExclusive", {31'd0, rxIf.o_valid & rxIf.o_frameErr}, 32'd0);
            if (expQ.size() == 0) begin
                check("unexpectedStrobe", {31'd0, rxIf.o_frameErr}, {31'd0, rxIf.o_valid});
                check("unexpectedStrobe", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                check("strobeKind", {31'd0, rxIf.o_frameErr}, {31'd0, e.isErr});
                check(e.isErr ? "heldData" : "rxData", {24'd0, rxIf.o_data}, {24'd0, e.data});
                if (!e.isErr) check("busyAfterByte", {31'd0, rxIf.o_busy}, 32'd0);
                if (e.chkLat) check("latency", cycleCnt - e.startCyc, 32'd1543);
            end
        end
    end

    task automatic driveBit(input logic v, input int n, input int spikeAt);
        for (int i = 0; i < n; i++) begin
            i_serialIn = (i == spikeAt) ? ~v : v;
            @(posedge i_clk); #1;
        end
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopVal, input int bitLen,
                             input bit push, input int spikeOff, input bit chkLat);
        exp_t e;
        if (push) begin
            e.isErr    = !stopVal;
            e.data     = stopVal ? d : lastGood;
            e.chkLat   = chkLat;
            e.startCyc = cycleCnt;
            expQ.push_back(e);
            if (stopVal) lastGood = d;
        end
        driveBit(1'b0, bitLen, -1);
        for (int i = 0; i < 8; i++) driveBit(d[i], bitLen, d[i] ? spikeOff : -1);
        driveBit(stopVal, bitLen, -1);
    endtask

    task automatic waitDrain(input int maxCyc);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < maxCyc) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (expQ.size() != 0) check("drainTimeout", expQ.size(), 32'd0);
    endtask

    initial begin
        @(negedge i_clk);
        check("rstValid", {31'd0, rxIf.o_valid}, 32'd0);
        check("rstFrameErr", {31'd0, rxIf.o_frameErr}, 32'd0);
        check("rstData", {24'd0, rxIf.o_data}, 32'd0);
        check("rstBusy", {31'd0, rxIf.o_busy}, 32'd0);
        repeat (5) @(posedge i_clk);
        #1 i_resetn = 1'b1;
        driveBit(1'b1, 20, -1);

        // Single byte with latency check
        sendFrame(8'hA5, 1'b1, BIT, 1, -1, 1);
        driveBit(1'b1, 100, -1);
        waitDrain(400);

        // Back-to-back, nominal and +/-2 % skew
        sendFrame(8'h00, 1'b1, BIT, 1, -1, 0);
        sendFrame(8'hFF, 1'b1, BIT, 1, -1, 0);
        sendFrame(8'h55, 1'b1, BIT, 1, -1, 0);
        sendFrame(8'h00, 1'b1, 157, 1, -1, 0);
        sendFrame(8'hFF, 1'b1, 157, 1, -1, 0);
        sendFrame(8'h55, 1'b1, 157, 1, -1, 0);
        sendFrame(8'h00, 1'b1, 163, 1, -1, 0);
        sendFrame(8'hFF, 1'b1, 163, 1, -1, 0);
        sendFrame(8'h55, 1'b1, 163, 1, -1, 0);
        driveBit(1'b1, 50, -1);
        waitDrain(400);

        // Glitch on idle line
        driveBit(1'b0, 20, -1);
        check("glitchBusy", {31'd0, rxIf.o_busy}, 32'd1);
        driveBit(1'b0, 20, -1);
        driveBit(1'b1, 90, -1);
        check("glitchIdle", {31'd0, rxIf.o_busy}, 32'd0);
        driveBit(1'b1, 50, -1);

        // Single-cycle spikes landing on a sample point of every '1' data bit
        sendFrame(8'hB6, 1'b1, BIT, 1, 100, 0);
        sendFrame(8'h6D, 1'b1, BIT, 1, 80, 0);
        driveBit(1'b1, 50, -1);
        waitDrain(400);

        // Framing error followed by a line break, then a good byte
        sendFrame(8'h3C, 1'b0, BIT, 1, -1, 0);
        driveBit(1'b0, 3000, -1);
        driveBit(1'b1, 200, -1);
        check("breakDrained", expQ.size(), 32'd0);
        sendFrame(8'h81, 1'b1, BIT, 1, -1, 0);
        driveBit(1'b1, 50, -1);
        waitDrain(400);

        // Reset asserted in data bit 4 and released while the line is still low
        fork
            sendFrame(8'hC3, 1'b1, BIT, 0, -1, 0);
            begin
                repeat (850) @(posedge i_clk);
                #1 i_resetn = 1'b0;
                @(negedge i_clk);
                check("midRstValid", {31'd0, rxIf.o_valid}, 32'd0);
                check("midRstFrameErr", {31'd0, rxIf.o_frameErr}, 32'd0);
                check("midRstData", {24'd0, rxIf.o_data}, 32'd0);
                check("midRstBusy", {31'd0, rxIf.o_busy}, 32'd0);
                repeat (50) @(posedge i_clk);
                #1 i_resetn = 1'b1;
                lastGood = 8'h00;
            end
        join
        driveBit(1'b1, 200, -1);
        check("remnantIgnored", {31'd0, rxIf.o_busy}, 32'd0);
        sendFrame(8'h12, 1'b1, BIT, 1, -1, 0);
        driveBit(1'b1, 50, -1);
        waitDrain(400);

        check("queueEmpty", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
